// File: rtl/syn_bht_predictor_pkg.sv
// Shared constants and types for the branch history table predictor:
// fetch-address width, default table depth and 2-bit counter encodings.
package syn_bht_predictor_pkg;

    // Word-addressed instruction memory PC width.
    localparam int unsigned IM_ADDR_BIT = 10;

    // Default number of predictor entries.
    localparam int unsigned BHT_ENTRIES_DEF = 8;

    // Width of the per-entry direction counter.
    localparam int unsigned BHT_CNT_W = 2;

    // Direction counter states; the upper half predicts taken.
    typedef enum logic [BHT_CNT_W-1:0] {
        CntSnt = 2'd0,
        CntWnt = 2'd1,
        CntWt  = 2'd2,
        CntSt  = 2'd3
    } bht_cnt_e;

endpackage

// File: rtl/syn_bht_predictor_sat_counter2.sv
// Combinational 2-bit saturating counter step: increments on inc_i,
// otherwise decrements, clamping at strongly-taken / strongly-not-taken.
module sat_counter2
    import syn_bht_predictor_pkg::*;
(
    input  bht_cnt_e cnt_i,
    input  logic     inc_i,
    output bht_cnt_e cnt_o
);

    // Saturating increment/decrement of the current counter value.
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != CntSt) begin
                cnt_o = bht_cnt_e'(cnt_i + 2'd1);
            end
        end else begin
            if (cnt_i != CntSnt) begin
                cnt_o = bht_cnt_e'(cnt_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/syn_bht_predictor.sv
// Fully associative branch history table with round-robin allocation.
// Lookup is combinational from registered state; updates land on the next
// clock edge. Optional hit/mispredict statistics under BHT_STATS_EN.
module syn_bht_predictor
    import syn_bht_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = BHT_ENTRIES_DEF,
    parameter int unsigned ADDR_BIT = IM_ADDR_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ADDR_BIT-1:0] lk_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [ADDR_BIT-1:0] pred_target,
`ifdef BHT_STATS_EN
    output logic [15:0]         stat_pred,
    output logic [15:0]         stat_miss,
`endif
    input  logic                upd_en,
    input  logic [ADDR_BIT-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [ADDR_BIT-1:0] upd_target,
    input  logic                upd_mispredict
);

    localparam int unsigned PtrW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic                valid_q  [ENTRIES];
    logic [ADDR_BIT-1:0] tag_q    [ENTRIES];
    logic [ADDR_BIT-1:0] target_q [ENTRIES];
    bht_cnt_e            cnt_q    [ENTRIES];
    logic [PtrW-1:0]     ptr_q;

    logic                lk_hit;
    logic [PtrW-1:0]     lk_idx;
    logic                up_hit;
    logic [PtrW-1:0]     up_idx;
    bht_cnt_e            cnt_next;

    // Associative search for the fetch PC (tags are unique, so any match wins).
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lk_pc)) begin
                lk_hit = 1'b1;
                lk_idx = PtrW'(i);
            end
        end
    end

    // Associative search for the resolved PC.
    always_comb begin
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == upd_pc)) begin
                up_hit = 1'b1;
                up_idx = PtrW'(i);
            end
        end
    end

    sat_counter2 u_sat_counter2 (
        .cnt_i (cnt_q[up_idx]),
        .inc_i (upd_taken),
        .cnt_o (cnt_next)
    );

    assign pred_hit    = lk_hit;
    assign pred_taken  = lk_hit && (cnt_q[lk_idx] >= CntWt);
    assign pred_target = pred_taken ? target_q[lk_idx] : lk_pc + ADDR_BIT'(1);

    // Table update: train a hit entry, or allocate on a taken miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (en && upd_en) begin
            if (up_hit) begin
                cnt_q[up_idx] <= cnt_next;
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[ptr_q]  <= 1'b1;
                tag_q[ptr_q]    <= upd_pc;
                target_q[ptr_q] <= upd_target;
                cnt_q[ptr_q]    <= CntWt;
                ptr_q           <= (ptr_q == PtrW'(ENTRIES - 1)) ? '0 : ptr_q + PtrW'(1);
            end
        end
    end

`ifdef BHT_STATS_EN
    logic [15:0] stat_pred_q;
    logic [15:0] stat_miss_q;

    // Saturating counters of taken predictions and reported mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pred_q <= '0;
            stat_miss_q <= '0;
        end else if (en) begin
            if (pred_taken && (stat_pred_q != 16'hFFFF)) begin
                stat_pred_q <= stat_pred_q + 16'd1;
            end
            if (upd_en && upd_mispredict && (stat_miss_q != 16'hFFFF)) begin
                stat_miss_q <= stat_miss_q + 16'd1;
            end
        end
    end

    assign stat_pred = stat_pred_q;
    assign stat_miss = stat_miss_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif

endmodule
